// File: rtl/line_router_pkg.sv
// line_router_pkg: shared types, default parameters and the line-hit helper
// for the registered byte router between feature-map SRAM and PE lanes.
package line_router_pkg;

    localparam int LR_NUM_LANES      = 16;
    localparam int LR_BYTES_PER_LINE = 16;
    localparam int LR_ADDR_W         = 13;
    localparam int LR_DATA_W         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lane_state_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] offset;
    } hit_res_t;

    // addr and base arrive zero-extended from ADDR_W, so the borrow out of
    // this 33-bit subtraction is the sign of an ADDR_W+1-bit difference.
    // A line near the top of the address space therefore never wraps to 0.
    function automatic hit_res_t hit_offset(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned bpl);
        logic [32:0] diff;
        hit_res_t    res;
        diff       = {1'b0, addr} - {1'b0, base};
        res.hit    = !diff[32] && (diff[31:0] < bpl);
        res.offset = diff[31:0];
        return res;
    endfunction

endpackage

// File: rtl/line_router_if.sv
// line_router_if: line broadcast, per-lane request and per-lane result
// handshakes of line_router, bundled with master (requester side) and
// slave (router side) modports.
interface line_router_if
    import line_router_pkg::*;
#(
    parameter int NUM_LANES      = LR_NUM_LANES,
    parameter int BYTES_PER_LINE = LR_BYTES_PER_LINE,
    parameter int ADDR_W         = LR_ADDR_W,
    parameter int DATA_W         = LR_DATA_W
) ();

    logic                             line_valid;
    logic [ADDR_W-1:0]                line_base;
    logic [BYTES_PER_LINE*DATA_W-1:0] line_data;

    logic [NUM_LANES-1:0]             req_valid;
    logic [NUM_LANES-1:0]             req_ready;
    logic [NUM_LANES*ADDR_W-1:0]      req_addr;

    logic [NUM_LANES-1:0]             out_valid;
    logic [NUM_LANES-1:0]             out_ready;
    logic [NUM_LANES*DATA_W-1:0]      out_data;

    modport master (
        output line_valid, line_base, line_data,
        output req_valid, req_addr, out_ready,
        input  req_ready, out_valid, out_data
    );

    modport slave (
        input  line_valid, line_base, line_data,
        input  req_valid, req_addr, out_ready,
        output req_ready, out_valid, out_data
    );

endinterface

// File: rtl/line_router_lane.sv
// line_router_lane: one PE lane. Latches a byte address, waits for a line
// beat that covers it, captures the byte and holds it until consumed.
// With LINE_ROUTER_STATS_EN defined, exposes a per-beat hit strobe.
module line_router_lane
    import line_router_pkg::*;
#(
    parameter int BYTES_PER_LINE = LR_BYTES_PER_LINE,
    parameter int ADDR_W         = LR_ADDR_W,
    parameter int DATA_W         = LR_DATA_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             line_valid_i,
    input  logic [ADDR_W-1:0]                line_base_i,
    input  logic [BYTES_PER_LINE*DATA_W-1:0] line_data_i,
    input  logic                             req_valid_i,
    input  logic [ADDR_W-1:0]                req_addr_i,
    output logic                             req_ready_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_W-1:0]                out_data_o
`ifdef LINE_ROUTER_STATS_EN
    ,
    output logic                             hit_o
`endif
);

    lane_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    hit_res_t          hres;
    logic              line_hit;

    // State, address latch and output byte register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next state: accept request in IDLE, match a line in WAIT, drain in DONE
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        hres     = hit_offset(32'(addr_q), 32'(line_base_i), BYTES_PER_LINE);
        // only a lane already in WAIT can hit, so a line in the request
        // cycle is never matched
        line_hit = (state_q == WAIT) && line_valid_i && hres.hit;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (line_hit) begin
                    data_d  = DATA_W'(line_data_i >> (hres.offset * DATA_W));
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign out_data_o  = data_q;
`ifdef LINE_ROUTER_STATS_EN
    assign hit_o       = line_hit;
`endif

endmodule

// File: rtl/line_router.sv
// line_router: broadcasts each SRAM line beat to NUM_LANES independent lanes;
// every lane returns its requested byte through a valid/ready handshake.
// Optional build macro LINE_ROUTER_STATS_EN adds saturating stat_hits and
// stat_idle_lines counters.
module line_router
    import line_router_pkg::*;
#(
    parameter int NUM_LANES      = LR_NUM_LANES,
    parameter int BYTES_PER_LINE = LR_BYTES_PER_LINE,
    parameter int ADDR_W         = LR_ADDR_W,
    parameter int DATA_W         = LR_DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    line_router_if.slave bus
`ifdef LINE_ROUTER_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_idle_lines
`endif
);

    logic [NUM_LANES-1:0]        req_ready_w;
    logic [NUM_LANES-1:0]        out_valid_w;
    logic [NUM_LANES*DATA_W-1:0] out_data_w;
`ifdef LINE_ROUTER_STATS_EN
    logic [NUM_LANES-1:0]        lane_hit;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        line_router_lane #(
            .BYTES_PER_LINE (BYTES_PER_LINE),
            .ADDR_W         (ADDR_W),
            .DATA_W         (DATA_W)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .line_valid_i (bus.line_valid),
            .line_base_i  (bus.line_base),
            .line_data_i  (bus.line_data),
            .req_valid_i  (bus.req_valid[g]),
            .req_addr_i   (bus.req_addr[g*ADDR_W +: ADDR_W]),
            .req_ready_o  (req_ready_w[g]),
            .out_valid_o  (out_valid_w[g]),
            .out_ready_i  (bus.out_ready[g]),
            .out_data_o   (out_data_w[g*DATA_W +: DATA_W])
`ifdef LINE_ROUTER_STATS_EN
            ,
            .hit_o        (lane_hit[g])
`endif
        );
    end

    assign bus.req_ready = req_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;

`ifdef LINE_ROUTER_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_idle_q, stat_idle_d;
    logic [31:0] hit_cnt;
    logic [32:0] hit_sum;

    // Saturating counters: hits per beat and beats that served no lane
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) hit_cnt = hit_cnt + 32'(lane_hit[i]);
        hit_sum     = {1'b0, stat_hits_q} + {1'b0, hit_cnt};
        stat_hits_d = hit_sum[32] ? '1 : hit_sum[31:0];
        stat_idle_d = stat_idle_q;
        if (bus.line_valid && (lane_hit == '0) && (stat_idle_q != '1))
            stat_idle_d = stat_idle_q + 32'd1;
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hits_q <= '0;
            stat_idle_q <= '0;
        end else begin
            stat_hits_q <= stat_hits_d;
            stat_idle_q <= stat_idle_d;
        end
    end

    assign stat_hits       = stat_hits_q;
    assign stat_idle_lines = stat_idle_q;
`endif

endmodule

// File: tb/tb_line_router.sv
// tb_line_router: directed plus randomized checks of line_router against a
// per-lane behavioural model (pending address / delivered byte per lane).
module tb_line_router;

    localparam int NL  = 16;
    localparam int BPL = 16;
    localparam int AW  = 13;
    localparam int DW  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_router_if #(.NUM_LANES(NL), .BYTES_PER_LINE(BPL), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef LINE_ROUTER_STATS_EN
    logic [31:0] stat_hits, stat_idle_lines;
`endif

    line_router #(.NUM_LANES(NL), .BYTES_PER_LINE(BPL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LINE_ROUTER_STATS_EN
        ,
        .stat_hits       (stat_hits),
        .stat_idle_lines (stat_idle_lines)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // reference model
    bit          m_wait [NL];
    bit          m_have [NL];
    int          m_addr [NL];
    logic [7:0]  m_byte [NL];
    longint      m_hits;
    longint      m_idle;

    function automatic void model_edge();
        int hits;
        hits = 0;
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) begin
                m_wait[i] = 0; m_have[i] = 0; m_byte[i] = 8'h00;
            end
            m_hits = 0; m_idle = 0;
            return;
        end
        for (int i = 0; i < NL; i++) begin
            if (m_have[i]) begin
                if (bus.out_ready[i]) m_have[i] = 0;
            end else if (m_wait[i]) begin
                int off;
                off = m_addr[i] - int'(bus.line_base);
                if (bus.line_valid && off >= 0 && off < BPL) begin
                    m_byte[i] = 8'(bus.line_data >> (DW * off));
                    m_wait[i] = 0;
                    m_have[i] = 1;
                    hits++;
                end
            end else if (bus.req_valid[i]) begin
                m_wait[i] = 1;
                m_addr[i] = int'(bus.req_addr[i*AW +: AW]);
            end
        end
        if (bus.line_valid) begin
            m_hits = m_hits + hits;
            if (m_hits > 64'hFFFF_FFFF) m_hits = 64'hFFFF_FFFF;
            if (hits == 0 && m_idle < 64'hFFFF_FFFF) m_idle++;
        end
    endfunction

    task automatic cmp(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NL-1:0]    e_rdy, e_vld;
        logic [NL*DW-1:0] e_data;
        for (int i = 0; i < NL; i++) begin
            e_rdy[i]            = !m_wait[i] && !m_have[i];
            e_vld[i]            = m_have[i];
            e_data[i*DW +: DW]  = m_byte[i];
        end
        cmp({tag, ".req_ready"}, 128'(bus.req_ready), 128'(e_rdy));
        cmp({tag, ".out_valid"}, 128'(bus.out_valid), 128'(e_vld));
        cmp({tag, ".out_data"},  128'(bus.out_data),  128'(e_data));
`ifdef LINE_ROUTER_STATS_EN
        cmp({tag, ".stat_hits"}, 128'(stat_hits),       128'(m_hits[31:0]));
        cmp({tag, ".stat_idle"}, 128'(stat_idle_lines), 128'(m_idle[31:0]));
`endif
    endtask

    // model takes the edge with the inputs currently driven; outputs sampled 1 after
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] d;

    initial begin
        bus.line_valid = 1'b0;
        bus.line_base  = '0;
        bus.line_data  = '0;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.out_ready  = '0;

        // reset
        rst_n = 1'b0;
        step();
        check_all("reset");
        cmp("reset.req_ready_ones", 128'(bus.req_ready), 128'(16'hFFFF));
        rst_n = 1'b1;

        // all lanes from one line
        for (int i = 0; i < NL; i++) bus.req_addr[i*AW +: AW] = AW'(i);
        bus.req_valid = '1;
        step();
        check_all("t1_req");
        bus.req_valid  = '0;
        bus.line_valid = 1'b1;
        bus.line_base  = 13'h000;
        bus.line_data  = 128'h112233445566778899AABBCCDDEEFF00;
        step();
        bus.line_valid = 1'b0;
        check_all("t1_hit");
        cmp("t1.lane0",  128'(bus.out_data[7:0]),     128'(8'h00));
        cmp("t1.lane1",  128'(bus.out_data[15:8]),    128'(8'hFF));
        cmp("t1.lane15", 128'(bus.out_data[127:120]), 128'(8'h11));
        cmp("t1.valid",  128'(bus.out_valid),         128'(16'hFFFF));
`ifdef LINE_ROUTER_STATS_EN
        cmp("t1.stat_hits", 128'(stat_hits),       128'(32'd16));
        cmp("t1.stat_idle", 128'(stat_idle_lines), 128'(32'd0));
`endif
        bus.out_ready = '1;
        step();
        bus.out_ready = '0;
        check_all("t1_drain");

        // lane0 waits across two missing lines
        bus.req_addr[0 +: AW] = 13'h105;
        bus.req_valid[0] = 1'b1;
        step();
        bus.req_valid[0] = 1'b0;
        bus.line_valid = 1'b1;
        bus.line_base  = 13'h050;
        bus.line_data  = rand_line();
        step();
        check_all("t2_miss1");
        bus.line_base  = 13'h0F0;
        bus.line_data  = rand_line();
        step();
        cmp("t2.no_hit", 128'(bus.out_valid[0]), 128'(1'b0));
        d = rand_line();
        bus.line_base  = 13'h100;
        bus.line_data  = d;
        step();
        bus.line_valid = 1'b0;
        check_all("t2_hit");
        cmp("t2.valid0", 128'(bus.out_valid[0]),  128'(1'b1));
        cmp("t2.byte5",  128'(bus.out_data[7:0]), 128'(d[47:40]));
        bus.out_ready[0] = 1'b1;
        step();
        bus.out_ready[0] = 1'b0;

        // offsets 0 and 15, lane5 just past the line
        bus.req_addr[3*AW +: AW] = 13'h020;
        bus.req_addr[4*AW +: AW] = 13'h02F;
        bus.req_addr[5*AW +: AW] = 13'h030;
        bus.req_valid[5:3] = 3'b111;
        step();
        bus.req_valid = '0;
        d = rand_line();
        bus.line_valid = 1'b1;
        bus.line_base  = 13'h020;
        bus.line_data  = d;
        step();
        bus.line_valid = 1'b0;
        check_all("t3_hit");
        cmp("t3.lane3_off0",  128'(bus.out_data[31:24]), 128'(d[7:0]));
        cmp("t3.lane4_off15", 128'(bus.out_data[39:32]), 128'(d[127:120]));
        cmp("t3.lane5_wait",  128'(bus.out_valid[5]),    128'(1'b0));
        bus.out_ready[4:3] = 2'b11;
        step();
        bus.out_ready = '0;

        // lane2 holds its byte under backpressure
        bus.req_addr[2*AW +: AW] = 13'h200;
        bus.req_valid[2] = 1'b1;
        step();
        bus.req_valid[2] = 1'b0;
        d = rand_line();
        bus.line_valid = 1'b1;
        bus.line_base  = 13'h200;
        bus.line_data  = d;
        step();
        for (int k = 0; k < 5; k++) begin
            bus.line_data = rand_line();
            step();
            check_all("t4_hold");
            cmp("t4.hold_byte", 128'(bus.out_data[23:16]), 128'(d[7:0]));
        end
        bus.line_valid   = 1'b0;
        bus.out_ready[2] = 1'b1;
        step();
        bus.out_ready[2] = 1'b0;
        cmp("t4.ready2", 128'(bus.req_ready[2]), 128'(1'b1));

        // no wrap at top of address space; same-cycle line not matched
        bus.req_addr[1*AW +: AW] = 13'h0003;
        bus.req_valid[1] = 1'b1;
        step();
        bus.req_valid[1] = 1'b0;
        bus.line_valid = 1'b1;
        bus.line_base  = 13'h1FF8;
        bus.line_data  = rand_line();
        step();
        cmp("t5.no_wrap",   128'(bus.out_valid[1]), 128'(1'b0));
        cmp("t5.still_wait", 128'(bus.req_ready[1]), 128'(1'b0));
        bus.req_addr[6*AW +: AW] = 13'h0040;
        bus.req_valid[6] = 1'b1;
        bus.line_base    = 13'h0040;
        bus.line_data    = rand_line();
        step();
        bus.req_valid[6] = 1'b0;
        check_all("t5_same_cycle");
        cmp("t5.same_cycle", 128'(bus.out_valid[6]), 128'(1'b0));
        bus.line_data = rand_line();
        step();
        bus.line_valid = 1'b0;
        cmp("t5.next_line", 128'(bus.out_valid[6]), 128'(1'b1));
        check_all("t5_served");
        bus.out_ready = '1;
        step();
        bus.out_ready = '0;

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NL'($urandom);
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 15) == 0)
                    bus.req_addr[i*AW +: AW] = AW'(13'h1FF0 + $urandom_range(0, 15));
                else
                    bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 159));
            end
            bus.line_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) bus.line_base = 13'h1FF8;
            else                            bus.line_base = AW'($urandom_range(0, 144));
            bus.line_data = rand_line();
            bus.out_ready = NL'($urandom);
            step();
            check_all("rand");
        end

        // reset with lanes in WAIT and DONE
        bus.line_valid = 1'b0;
        bus.out_ready  = '0;
        for (int i = 0; i < NL; i++) bus.req_addr[i*AW +: AW] = AW'(13'h300 + i);
        bus.req_valid = '1;
        step();
        bus.req_valid  = '0;
        bus.line_valid = 1'b1;
        bus.line_base  = 13'h300;
        bus.line_data  = rand_line();
        step();
        bus.line_valid = 1'b0;
        bus.out_ready  = 16'h00FF;
        step();
        bus.out_ready  = '0;
        bus.req_valid  = '1;
        step();
        bus.req_valid  = '0;
        check_all("t7_pre");
        rst_n = 1'b0;
        step();
        check_all("t7_reset");
        cmp("t7.valid0", 128'(bus.out_valid), 128'(16'h0000));
        cmp("t7.ready1", 128'(bus.req_ready), 128'(16'hFFFF));
        cmp("t7.data0",  128'(bus.out_data),  128'(0));
`ifdef LINE_ROUTER_STATS_EN
        cmp("t7.stat_hits0", 128'(stat_hits),       128'(0));
        cmp("t7.stat_idle0", 128'(stat_idle_lines), 128'(0));
`endif
        rst_n = 1'b1;
        bus.line_valid = 1'b1;
        bus.line_base  = 13'h300;
        bus.line_data  = rand_line();
        step();
        bus.line_valid = 1'b0;
        cmp("t7.discarded", 128'(bus.out_valid), 128'(16'h0000));
        check_all("t7_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/line_router.md
# line_router

Registered, parametrised successor to the combinational byte router between the feature-map SRAM and the PE lanes. A base-addressed SRAM line of BYTES_PER_LINE bytes is broadcast to NUM_LANES lanes. Each lane holds its own outstanding byte request across several line beats, then returns the matching byte through a valid/ready handshake. It sits between the SRAM read port and the PE input registers of the fused-block datapath.

## Interface
- NUM_LANES, 16, number of PE lanes
- BYTES_PER_LINE, 16, bytes per SRAM line (power of two, ≥2)
- ADDR_W, 13, byte-address width
- DATA_W, 8, byte width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- line_valid  in  1  line beat present (always accepted; no line backpressure)
- line_base  in  ADDR_W  byte address of byte 0 of the line
- line_data  in  BYTES_PER_LINE*DATA_W  byte k at bits [k*DATA_W +: DATA_W]
- req_valid  in  NUM_LANES  per-lane request strobe
- req_ready  out  NUM_LANES  lane can accept a request
- req_addr  in  NUM_LANES*ADDR_W  lane i address at [i*ADDR_W +: ADDR_W]
- out_valid  out  NUM_LANES  lane byte available
- out_ready  in  NUM_LANES  lane consumer accepts byte
- out_data  out  NUM_LANES*DATA_W  lane i byte at [i*DATA_W +: DATA_W]

## Operation
- Each lane runs an independent three-state FSM: IDLE → WAIT → DONE → IDLE.
- IDLE: req_ready=1. On req_valid, latch req_addr and go to WAIT.
- WAIT: on line_valid with a hit, capture line byte (addr−line_base) into the lane output register and go to DONE. With no hit, stay in WAIT indefinitely.
- DONE: out_valid=1 and out_data stable. When out_ready=1, go to IDLE.
- Hit rule: line_base ≤ addr < line_base+BYTES_PER_LINE. Evaluated with an ADDR_W+1-bit difference.
  - A line at the top of the address space does not wrap to address 0.
  - addr == line_base is a hit at offset 0.
- One line may hit any number of lanes, including all of them, in the same cycle.

## Timing
- Reset (rst_n=0 at an edge): every lane goes to IDLE, req_ready=all 1, out_valid=0, out_data=0. Reset mid-request discards the request without delivering it.
- Request accepted at edge T; the earliest matching line is one presented at edge T+1.
  - A line presented at edge T, in the same cycle as the request, is not matched.
- Line hit at edge T: out_valid=1 and out_data valid from T+1. One cycle of latency.
- DONE with out_ready=1 at edge T: IDLE at T+1 and req_ready=1 at T+1. A new request can be accepted at T+1, so throughput is one byte per lane every 3 cycles minimum.
- A lane in DONE ignores line beats. out_data holds while out_ready=0.
- req_valid while req_ready=0 is ignored. The requester must hold req_valid until it sees req_ready.

## Configuration
- LINE_ROUTER_STATS_EN defined: adds two outputs, stat_hits [31:0] and stat_idle_lines [31:0]. Both reset to 0 and saturate at all-ones.
  - stat_hits adds the per-beat popcount of lane hits.
  - stat_idle_lines increments on each line_valid beat that hits no lane.
- LINE_ROUTER_STATS_EN undefined: the two ports and the counters are absent. All other behaviour is identical.

## Structure
- line_router_pkg:
  - lane_state_e enum: IDLE, WAIT, DONE, 2-bit encoding.
  - Default parameter constants.
  - Function hit_offset(addr, base), returning hit flag and offset.
- Sub-module line_router_lane: one lane's FSM, address latch and output register.
  - The top level is a generate loop over NUM_LANES.
  - The top level also holds the stats counters when they are compiled in.

## Test plan
- Defaults, line_base=0x000, lanes 0..15 request 0x000..0x00F. Next cycle, line_data=0x112233445566778899AABBCCDDEEFF00 → at +1: lane0=0x00, lane1=0xFF, lane15=0x11, out_valid=0xFFFF.
- Lane0 requests 0x105; lines at base 0x050, then 0x0F0, then 0x100 → no hit on the first two; lane0 byte 5 of the third line; out_valid[0] rises one cycle after the third line.
- Lane3 requests 0x020 and lane4 requests 0x02F against base 0x020 → both hit at offsets 0 and 15. Lane5 requests 0x030 → stays in WAIT.
- Lane2 in DONE, out_ready=0 for 5 cycles, lines keep arriving → out_data unchanged. out_ready=1 → req_ready[2]=1 on the next cycle.
- Line at base 0x1FF8 while lane1 waits on 0x0003 → no hit (no wrap). A request arriving in the same cycle as its matching line → not served by that line.
- rst_n=0 while lanes are in WAIT/DONE → all IDLE, out_valid=0. With LINE_ROUTER_STATS_EN, test 1 gives stat_hits=16 and stat_idle_lines=0, and the counters clear on reset.
